// File: rtl/demux_pkg.sv
// Shared types and defaults for the burst-loading demultiplexer.
package demux_pkg;

  localparam int unsigned SEL_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BURST  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/demux_ptr.sv
// Loadable wrapping up-counter used as the burst write pointer.
module demux_ptr #(
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [SEL_W-1:0] load_val,
  input  logic             inc,
  output logic [SEL_W-1:0] q
);

  localparam logic [SEL_W-1:0] ONE = SEL_W'(1);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (inc) begin
      q <= q + ONE;  // natural wrap from N-1 to 0
    end
  end

endmodule

// File: rtl/demux_burst.sv
// Registered 1-to-N demux: single-bit writes or handshaked bursts staged
// in a shadow bank and published to y in one cycle.
module demux_burst
  import demux_pkg::*;
#(
  parameter int SEL_W = SEL_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               d,
  input  logic [SEL_W-1:0]   s,
  input  logic [SEL_W-1:0]   len,
  input  logic               wr,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               clr,
  output logic               busy,
  output logic               done,
  output logic [2**SEL_W-1:0] y
);

  localparam int N = 2**SEL_W;
  localparam logic [SEL_W-1:0] CNT_ONE = SEL_W'(1);

  state_t           state;
  logic [N-1:0]     sh;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] cnt;
  logic             ptr_load;
  logic             ptr_inc;

  // Moore outputs: decoded from state only.
  assign busy     = (state != ST_IDLE);
  assign in_ready = (state == ST_BURST);

  assign ptr_load = !clr && (state == ST_IDLE) && start;
  assign ptr_inc  = !clr && (state == ST_BURST) && in_valid;

  demux_ptr #(
    .SEL_W (SEL_W)
  ) u_ptr (
    .clk      (clk),
    .rst      (rst),
    .load     (ptr_load),
    .load_val (s),
    .inc      (ptr_inc),
    .q        (ptr)
  );

  // NOTE: both banks are plain flop vectors, so they take the reset value like any other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      y     <= '0;
      sh    <= '0;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clr) begin
        // Abort anything in flight; no done pulse for a discarded burst.
        y     <= '0;
        sh    <= '0;
        state <= ST_IDLE;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (start) begin
              // Shadow starts as a copy of y so unwritten bits keep their value.
              sh    <= y;
              cnt   <= len;
              state <= ST_BURST;
            end else if (wr) begin
              y[s]  <= d;
              sh[s] <= d;
            end
          end
          ST_BURST: begin
            if (in_valid) begin
              sh[ptr] <= d;
              if (cnt == '0) begin
                state <= ST_COMMIT;
              end else begin
                cnt <= cnt - CNT_ONE;
              end
            end
          end
          ST_COMMIT: begin
            y     <= sh;
            done  <= 1'b1;
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_demux_burst.sv
// Scoreboard bench for demux_burst: stimulus pushes expected bursts, a monitor checks each done pulse.
module tb_demux_burst;
  import demux_pkg::*;

  localparam int SEL_W = SEL_W_DEFAULT;
  localparam int N     = 1 << SEL_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             d;
  logic [SEL_W-1:0] s;
  logic [SEL_W-1:0] len;
  logic             wr;
  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic             clr;
  logic             busy;
  logic             done;
  logic [N-1:0]     y;

  typedef struct {
    logic [N-1:0] y;
    int           cyc;
  } exp_t;

  exp_t         exp_q[$];
  logic [N-1:0] model_y = '0;
  int           stall_plan[N];
  int           n_checks = 0;
  int           n_fail   = 0;
  int           cyc      = 0;

  demux_burst #(
    .SEL_W (SEL_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .d        (d),
    .s        (s),
    .len      (len),
    .wr       (wr),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .clr      (clr),
    .busy     (busy),
    .done     (done),
    .y        (y)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // All tasks begin and end 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_bit(input int a, input logic v);
    wr = 1'b1;
    s  = a[SEL_W-1:0];
    d  = v;
    step();
    wr = 1'b0;
    model_y[a] = v;
    check("wr_y", 32'(y), 32'(model_y));
    check("wr_busy", 32'(busy), 0);
  endtask

  task automatic clear();
    clr = 1'b1;
    step();
    clr = 1'b0;
    model_y = '0;
    check("clr_y", 32'(y), 0);
    check("clr_busy", 32'(busy), 0);
    check("clr_done", 32'(done), 0);
  endtask

  task automatic noise_drive(input bit noise);
    logic [31:0] r;
    if (noise) begin
      r     = $urandom;
      wr    = 1'b1;
      start = r[0];
      d     = r[1];
      s     = r[SEL_W+1:2];
    end
  endtask

  // Burst of l+1 bits from s0; stall_plan[i] idle cycles precede bit i.
  task automatic do_burst(input int s0, input int l, input logic [N-1:0] data, input bit noise);
    logic [N-1:0] pre;
    int           total;
    int           w;
    exp_t         e;
    pre   = model_y;
    total = 0;
    for (int i = 0; i <= l; i++) begin
      model_y[(s0 + i) % N] = data[i];
      total += stall_plan[i];
    end
    e.y   = model_y;
    e.cyc = cyc + 1 + (l + 1) + total + 1;
    exp_q.push_back(e);

    start = 1'b1;
    s     = s0[SEL_W-1:0];
    len   = l[SEL_W-1:0];
    step();
    start = 1'b0;
    wr    = 1'b0;
    check("burst_busy", 32'(busy), 1);
    check("burst_y_hold", 32'(y), 32'(pre));
    for (int i = 0; i <= l; i++) begin
      for (int k = 0; k < stall_plan[i]; k++) begin
        in_valid = 1'b0;
        noise_drive(noise);
        step();
        check("stall_in_ready", 32'(in_ready), 1);
        check("stall_y_hold", 32'(y), 32'(pre));
      end
      in_valid = 1'b1;
      noise_drive(noise);
      d = data[i];
      step();
      if (i < l) begin
        check("burst_in_ready", 32'(in_ready), 1);
        check("burst_y_hold", 32'(y), 32'(pre));
      end
    end
    in_valid = 1'b0;
    wr       = 1'b0;
    start    = 1'b0;
    check("commit_in_ready", 32'(in_ready), 0);
    check("commit_y_hold", 32'(y), 32'(pre));
    w = 0;
    while (busy && w < 8) begin
      step();
      w++;
    end
    check("burst_end_busy", 32'(busy), 0);
    for (int i = 0; i < N; i++) stall_plan[i] = 0;
  endtask

  // Monitor: every done pulse must match the oldest outstanding burst.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(done), 0);
        end else begin
          e = exp_q.pop_front();
          check("done_y", 32'(y), 32'(e.y));
          check("done_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r32;
    logic [N-1:0] rd;
    int           op;
    int           a;
    int           l;
    for (int i = 0; i < N; i++) stall_plan[i] = 0;
    rst = 1'b1; d = 1'b0; s = '0; len = '0; wr = 1'b0;
    start = 1'b0; in_valid = 1'b0; clr = 1'b0;

    // Reset
    step();
    step();
    rst = 1'b0;
    check("rst_y", 32'(y), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_in_ready", 32'(in_ready), 0);

    wr_bit(5, 1'b1);
    check("wr5_const", 32'(y), 32'h0020);
    clear();

    // Single writes on consecutive cycles
    wr_bit(0, 1'b1);
    wr_bit(3, 1'b1);
    wr_bit(15, 1'b1);
    check("wr_seq_const", 32'(y), 32'h8009);
    clear();

    // Burst with wrap: bits 14,15,0,1 = 1,0,1,1
    do_burst(14, 3, 16'b1101, 1'b0);
    check("wrap_const", 32'(y), 32'h4003);
    clear();

    // Same burst, 3 idle cycles after the second bit
    stall_plan[2] = 3;
    do_burst(14, 3, 16'b1101, 1'b0);
    check("stall_const", 32'(y), 32'h4003);
    clear();

    // Abort a full burst after 5 bits
    start = 1'b1; s = '0; len = 4'd15;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; d = 1'b1;
      step();
    end
    clr = 1'b1;
    step();
    clr = 1'b0; in_valid = 1'b0;
    model_y = '0;
    check("abort_y", 32'(y), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_in_ready", 32'(in_ready), 0);
    check("abort_done", 32'(done), 0);
    step();
    check("abort_done_late", 32'(done), 0);
    wr_bit(2, 1'b1);
    check("abort_wr_const", 32'(y), 32'h0004);
    clear();

    // start and wr together: the write is dropped
    wr = 1'b1; d = 1'b1;
    do_burst(6, 1, 16'b00, 1'b0);
    check("start_wr_const", 32'(y), 32'h0000);

    // wr/start noise during a burst is ignored
    do_burst(8, 3, 16'b1010, 1'b1);
    check("noise_const", 32'(y), 32'h0A00);
    clear();

    // Back-to-back: second start issued in the done cycle
    do_burst(0, 7, 16'h00FF, 1'b0);
    do_burst(4, 1, 16'h0000, 1'b0);
    check("b2b_const", 32'(y), 32'h00CF);

    // Randomized mix
    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 9);
      if (op < 4) begin
        wr_bit($urandom_range(0, N - 1), 1'($urandom_range(0, 1)));
      end else if (op < 9) begin
        a   = $urandom_range(0, N - 1);
        l   = $urandom_range(0, N - 1);
        r32 = $urandom;
        rd  = r32[N-1:0];
        for (int i = 0; i <= l; i++)
          stall_plan[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
        do_burst(a, l, rd, 1'($urandom_range(0, 1)));
        check("rand_y", 32'(y), 32'(model_y));
      end else begin
        clear();
      end
    end

    // Reset in the middle of a burst
    start = 1'b1; s = 4'd3; len = 4'd7;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; d = 1'b1;
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    model_y = '0;
    check("rst_mid_y", 32'(y), 0);
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_done", 32'(done), 0);
    wr_bit(9, 1'b1);
    check("rst_mid_wr_const", 32'(y), 32'h0200);

    step();
    step();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_burst.md
# demux_burst

Registered 1-to-N demultiplexer with burst loading. It writes single serial data bits into an N-bit output bank at a selected address, either one bit per strobe or as a handshaked burst with an auto-incrementing address. Burst data is staged in a shadow bank and published atomically on completion. It is the write-side counterpart of the wide select-indexed bit muxes in this codebase: it fills the vector those muxes read from.

## Interface
- SEL_W, default 4: select width. Bank size is N = 2**SEL_W, a derived localparam.
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-high.
- d  in  1  data bit.
- s  in  SEL_W  write address (single write) or burst start address.
- len  in  SEL_W  burst length minus one; 0 means 1 bit, N-1 means N bits.
- wr  in  1  single-bit write strobe.
- start  in  1  burst start strobe.
- in_valid  in  1  burst data valid.
- in_ready  out  1  burst data accepted when high together with in_valid.
- clr  in  1  synchronous clear of both banks.
- busy  out  1  high in BURST and COMMIT.
- done  out  1  one-cycle pulse when a burst is published.
- y  out  N  committed output bank.

## Operation
- State machine: IDLE, BURST, COMMIT. Internal signals: shadow bank sh[N-1:0], pointer ptr[SEL_W-1:0], remaining count cnt[SEL_W-1:0].
- Reset: state IDLE, y=0, sh=0, ptr=0, cnt=0, done=0. busy=0 and in_ready=0 follow from IDLE.
- Priority at each edge is clr, then start, then wr.
- clr: in any state, y<=0, sh<=0, state<=IDLE, no done pulse. An in-flight burst is aborted.
- IDLE with wr and no start: y[s]<=d and sh[s]<=d. Other bits are unchanged.
- IDLE with start: sh<=y, ptr<=s, cnt<=len, state<=BURST. A wr in the same cycle is dropped.
- start and wr while busy are ignored.
- BURST: in_ready=1. On in_valid, sh[ptr]<=d and ptr<=ptr+1 modulo N (wraps N-1→0).
  - If cnt==0, state<=COMMIT.
  - Otherwise cnt<=cnt-1.
  - When in_valid is low, all burst state holds with no timeout.
- COMMIT: y<=sh, done<=1, state<=IDLE.
- done is a registered output. It is high for exactly the one cycle after the COMMIT edge and is otherwise 0.
- A burst of length N starting at any s writes every bit exactly once.
- y never shows a partially loaded burst.

## Timing
- busy = (state!=IDLE) and in_ready = (state==BURST). Both are Moore outputs with no combinational path from inputs.
- Single write: wr sampled at edge k, y[s] shows the new value after edge k (1-cycle latency).
- Burst with L=len+1 bits and in_valid held high:
  - start sampled at edge 0.
  - Bits accepted at edges 1..L.
  - COMMIT occupies the cycle after edge L.
  - y updates and done rises after edge L+1.
  - busy falls after edge L+1.
- Every cycle with in_valid low during BURST adds one cycle to this latency.
- Back-to-back bursts: start may be asserted in the done cycle, because state is IDLE then. The second burst copies the freshly committed y into sh.
- Reset mid-burst behaves like clr: everything returns to reset values on that edge.

## Structure
- Package demux_pkg holds:
  - the typedef enum for IDLE/BURST/COMMIT (2-bit encoding);
  - the default SEL_W constant.
- One sub-module, demux_ptr: a loadable SEL_W-bit wrapping up-counter with a load value, an increment enable and synchronous reset. It is used for ptr. cnt stays inline.
- Top level is around 150–200 lines.

## Test plan
- Reset/clear (SEL_W=4): hold rst for 2 cycles → y=0, busy=0, done=0, in_ready=0. Then wr s=5 d=1, then clr → y=16'h0020 after the wr edge, y=0 after the clr edge.
- Single writes: wr with d=1 at s=0, 3 and 15 on consecutive cycles → y=16'h8009, each bit visible 1 cycle after its strobe, busy stays 0.
- Burst with wrap: s=14, len=3, data 1,0,1,1 with continuous in_valid → y bits 14,15,0,1 = 1,0,1,1, so y=16'h4003 (starting from y=0). done is high for 1 cycle, 6 cycles after start; y is unchanged until done.
- Stall: same burst with in_valid low for 3 cycles after the 2nd bit → identical final y, done 3 cycles later, in_ready high throughout BURST.
- Abort: start a full burst (len=15), assert clr after 5 accepted bits → y=0, no done, busy=0 next cycle. A later wr s=2 d=1 works → y=16'h0004.
- Collisions:
  - start and wr in the same cycle → wr dropped.
  - wr during BURST → ignored.
  - start in the done cycle → second burst begins; its unwritten bits keep the first burst's values.
